// File: rtl/tt_um_accelshark_psg_regfile.sv
// SharkPSG control register file. Takes a nybble-serial host bus, writes words into a
// shadow bank, and copies the whole shadow bank to the live bank on a single edge.
module psg_reg_slot #(
  parameter int DATA_W = 8,
  parameter int SHADOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              commit,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] live
);
  if (SHADOW != 0) begin : g_shadow
    logic [DATA_W-1:0] shadow;
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow <= '0;
        live   <= '0;
      end else begin
        if (wr) shadow <= word;
        // A word landing on the commit edge goes straight into the copy.
        if (commit) live <= wr ? word : shadow;
      end
    end
  end else begin : g_direct
    logic unused_commit;
    assign unused_commit = commit;
    always_ff @(posedge clk) begin
      if (rst)     live <= '0;
      else if (wr) live <= word;
    end
  end
endmodule

module tt_um_accelshark_psg_regfile #(
  parameter int NREGS    = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_NYB = 1,
  parameter int SHADOW   = 1,
  parameter int AUTO_INC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    strobe,
  input  logic                    address,
  input  logic [3:0]              da,
  input  logic                    commit,
  output logic [NREGS*DATA_W-1:0] regs,
  output logic [DATA_W-1:0]       rd_data,
  output logic [4*ADDR_NYB-1:0]   cur_addr,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic                    dirty
);
  localparam int DNYB = DATA_W / 4;
  localparam int AW   = 4 * ADDR_NYB;
  localparam int CW   = (DNYB > 1) ? $clog2(DNYB) : 1;

  logic [AW-1:0]     addr_q, addr_shift;
  logic [DATA_W-1:0] asm_q, word;
  logic [CW-1:0]     cnt;
  logic              stb_addr, stb_data, word_done, commit_eff, in_range, at_last;
  logic [31:0]       addr_ext;
  logic [NREGS-1:0][DATA_W-1:0] live;

  assign stb_addr   = ena & strobe & address;
  assign stb_data   = ena & strobe & ~address;
  assign word_done  = stb_data & (cnt == CW'(DNYB - 1));
  assign commit_eff = ena & commit & (SHADOW != 0);
  assign addr_ext   = {{(32-AW){1'b0}}, addr_q};
  assign in_range   = addr_ext < 32'(NREGS);
  assign at_last    = addr_ext >= 32'(NREGS - 1);

  if (DNYB == 1) begin : g_word1
    assign word = da;
  end else begin : g_wordn
    assign word = {asm_q[DATA_W-5:0], da};
  end

  if (ADDR_NYB == 1) begin : g_addr1
    assign addr_shift = da;
  end else begin : g_addrn
    assign addr_shift = {addr_q[AW-5:0], da};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      asm_q   <= '0;
      cnt     <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      dirty   <= 1'b0;
    end else begin
      wr_done <= word_done;
      wr_err  <= word_done & ~in_range;
      if (stb_addr) begin
        addr_q <= addr_shift;
        cnt    <= '0;
      end else if (stb_data) begin
        if (word_done) begin
          cnt <= '0;
          if (AUTO_INC != 0) addr_q <= at_last ? '0 : addr_q + 1'b1;
        end else begin
          asm_q <= word;
          cnt   <= cnt + 1'b1;
        end
      end
      if (commit_eff)                  dirty <= 1'b0;
      else if (word_done && in_range)  dirty <= (SHADOW != 0);
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_slot
    psg_reg_slot #(.DATA_W(DATA_W), .SHADOW(SHADOW)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .wr    (word_done & (addr_q == AW'(i))),
      .commit(commit_eff),
      .word  (word),
      .live  (live[i])
    );
    assign regs[i*DATA_W +: DATA_W] = live[i];
  end

  // Matching any slot implies the address is in range, so no separate bound check.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++)
      if (addr_q == AW'(i)) rd_data = live[i];
  end

  assign cur_addr = addr_q;
endmodule

// File: tb/tb_tt_um_accelshark_psg_regfile.sv
// Bench for the PSG register file: directed vector table plus random traffic against
// a word-level model on the default build, and a directed run on a 16-bit direct-write build.
module tb_tt_um_accelshark_psg_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Default build: NREGS=8, DATA_W=8, ADDR_NYB=1, SHADOW=1, AUTO_INC=1
  logic       a_rst = 1'b1, a_ena = 1'b0, a_stb = 1'b0, a_adr = 1'b0, a_com = 1'b0;
  logic [3:0] a_da = '0;
  logic [63:0] a_regs;
  logic [7:0]  a_rd;
  logic [3:0]  a_addr;
  logic        a_done, a_err, a_dirty;

  tt_um_accelshark_psg_regfile dut_a (
    .clk(clk), .rst(a_rst), .ena(a_ena), .strobe(a_stb), .address(a_adr), .da(a_da),
    .commit(a_com), .regs(a_regs), .rd_data(a_rd), .cur_addr(a_addr),
    .wr_done(a_done), .wr_err(a_err), .dirty(a_dirty)
  );

  // Sweep build: 20 x 16-bit registers, two address nybbles, no shadow bank
  logic       b_rst = 1'b1, b_ena = 1'b0, b_stb = 1'b0, b_adr = 1'b0, b_com = 1'b0;
  logic [3:0] b_da = '0;
  logic [319:0] b_regs;
  logic [15:0]  b_rd;
  logic [7:0]   b_addr;
  logic         b_done, b_err, b_dirty;

  tt_um_accelshark_psg_regfile #(.NREGS(20), .DATA_W(16), .ADDR_NYB(2), .SHADOW(0), .AUTO_INC(1)) dut_b (
    .clk(clk), .rst(b_rst), .ena(b_ena), .strobe(b_stb), .address(b_adr), .da(b_da),
    .commit(b_com), .regs(b_regs), .rd_data(b_rd), .cur_addr(b_addr),
    .wr_done(b_done), .wr_err(b_err), .dirty(b_dirty)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step_a(input logic r, e, s, ad, input logic [3:0] d, input logic c);
    @(negedge clk);
    a_rst = r; a_ena = e; a_stb = s; a_adr = ad; a_da = d; a_com = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic r, e, s, ad, input logic [3:0] d, input logic c);
    @(negedge clk);
    b_rst = r; b_ena = e; b_stb = s; b_adr = ad; b_da = d; b_com = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, e, s, ad;
    logic [3:0] d;
    logic c;
    int   idx;
    logic [7:0] lv;
    logic [3:0] addr;
    logic dirty, done, err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, e, s, ad, input logic [3:0] d, input logic c,
                     input int idx, input logic [7:0] lv, input logic [3:0] addr,
                     input logic di, dn, er);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.ad = ad; v.d = d; v.c = c;
    v.idx = idx; v.lv = lv; v.addr = addr; v.dirty = di; v.done = dn; v.err = er;
    tbl.push_back(v);
  endtask

  // Word-level model: pending nybbles collect in a queue until a full word is present.
  int m_sh[8], m_lv[8];
  int m_addr, m_dirty, m_done, m_err;
  int m_pend[$];

  task automatic model_step(input logic r, e, s, ad, input logic [3:0] d, input logic c);
    int w;
    m_done = 0; m_err = 0;
    if (r) begin
      foreach (m_sh[i]) begin m_sh[i] = 0; m_lv[i] = 0; end
      m_addr = 0; m_dirty = 0; m_pend.delete();
    end else begin
      if (e && s && ad) begin
        m_addr = d;
        m_pend.delete();
      end else if (e && s) begin
        m_pend.push_back(int'(d));
        if (m_pend.size() == 2) begin
          w = m_pend[0] * 16 + m_pend[1];
          m_pend.delete();
          m_done = 1;
          if (m_addr < 8) begin m_sh[m_addr] = w; m_dirty = 1; end
          else m_err = 1;
          m_addr = (m_addr >= 7) ? 0 : m_addr + 1;
        end
      end
      if (e && c) begin
        foreach (m_lv[i]) m_lv[i] = m_sh[i];
        m_dirty = 0;
      end
    end
  endtask

  function automatic logic [63:0] model_regs();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(m_lv[i]);
    return v;
  endfunction

  localparam int SNAP_ROW = 26;

  initial begin
    //   r e s a  da   c   idx live   addr  dty dn er
    add(1,0,0,0, 4'h0,0,  3, 8'h00, 4'h0, 0,0,0); // reset
    add(0,1,1,1, 4'h3,0,  3, 8'h00, 4'h3, 0,0,0); // basic write of 0xA5 to reg 3
    add(0,1,1,0, 4'hA,0,  3, 8'h00, 4'h3, 0,0,0);
    add(0,1,1,0, 4'h5,0,  3, 8'h00, 4'h4, 1,1,0);
    add(0,1,0,0, 4'h0,0,  3, 8'h00, 4'h4, 1,0,0);
    add(0,1,0,0, 4'h0,1,  3, 8'hA5, 4'h4, 0,0,0);
    add(0,1,1,1, 4'h7,0,  7, 8'h00, 4'h7, 0,0,0); // auto-increment wrap
    add(0,1,1,0, 4'h1,0,  7, 8'h00, 4'h7, 0,0,0);
    add(0,1,1,0, 4'h1,0,  7, 8'h00, 4'h0, 1,1,0);
    add(0,1,1,0, 4'h2,0,  0, 8'h00, 4'h0, 1,0,0);
    add(0,1,1,0, 4'h2,0,  0, 8'h00, 4'h1, 1,1,0);
    add(0,1,0,0, 4'h0,1,  7, 8'h11, 4'h1, 0,0,0);
    add(0,1,0,0, 4'h0,0,  0, 8'h22, 4'h1, 0,0,0);
    add(0,1,1,1, 4'h2,0,  2, 8'h00, 4'h2, 0,0,0); // abandoned word
    add(0,1,1,0, 4'hF,0,  2, 8'h00, 4'h2, 0,0,0);
    add(0,1,1,1, 4'h4,0,  2, 8'h00, 4'h4, 0,0,0);
    add(0,1,1,0, 4'h1,0,  4, 8'h00, 4'h4, 0,0,0);
    add(0,1,1,0, 4'h2,0,  4, 8'h00, 4'h5, 1,1,0);
    add(0,1,0,0, 4'h0,1,  4, 8'h12, 4'h5, 0,0,0);
    add(0,1,0,0, 4'h0,0,  2, 8'h00, 4'h5, 0,0,0);
    add(0,1,1,1, 4'h5,0,  5, 8'h00, 4'h5, 0,0,0); // same-edge commit
    add(0,1,1,0, 4'h3,0,  5, 8'h00, 4'h5, 0,0,0);
    add(0,1,1,0, 4'hC,1,  5, 8'h3C, 4'h6, 0,1,0);
    add(0,1,1,1, 4'h9,0,  3, 8'hA5, 4'h9, 0,0,0); // out of range
    add(0,1,1,0, 4'h7,0,  3, 8'hA5, 4'h9, 0,0,0);
    add(0,1,1,0, 4'h7,0,  3, 8'hA5, 4'h0, 0,1,1);
    add(0,1,0,0, 4'h0,1,  0, 8'h22, 4'h0, 0,0,0); // snapshot row
    add(0,0,1,1, 4'h6,0,  0, 8'h22, 4'h0, 0,0,0); // ena low
    add(0,0,1,0, 4'h1,1,  0, 8'h22, 4'h0, 0,0,0);
    add(0,0,1,0, 4'h2,0,  0, 8'h22, 4'h0, 0,0,0);
    add(0,1,1,0, 4'h9,0,  0, 8'h22, 4'h0, 0,0,0);
    add(0,1,1,0, 4'h9,0,  0, 8'h22, 4'h1, 1,1,0);
    add(0,0,0,0, 4'h0,1,  0, 8'h22, 4'h1, 1,0,0);
    add(0,1,0,0, 4'h0,1,  0, 8'h99, 4'h1, 0,0,0);
    add(0,1,1,0, 4'h4,0,  0, 8'h99, 4'h1, 0,0,0); // reset mid-word
    add(1,1,0,0, 4'h0,0,  0, 8'h00, 4'h0, 0,0,0);
    add(0,1,1,0, 4'h5,0,  0, 8'h00, 4'h0, 0,0,0);
    add(0,1,1,0, 4'h6,1,  0, 8'h56, 4'h1, 0,1,0);

    foreach (tbl[k]) begin
      step_a(tbl[k].r, tbl[k].e, tbl[k].s, tbl[k].ad, tbl[k].d, tbl[k].c);
      chk($sformatf("row%0d_live%0d", k, tbl[k].idx), 64'(a_regs[tbl[k].idx*8 +: 8]), 64'(tbl[k].lv));
      chk($sformatf("row%0d_addr", k),  64'(a_addr),  64'(tbl[k].addr));
      chk($sformatf("row%0d_dirty", k), 64'(a_dirty), 64'(tbl[k].dirty));
      chk($sformatf("row%0d_done", k),  64'(a_done),  64'(tbl[k].done));
      chk($sformatf("row%0d_err", k),   64'(a_err),   64'(tbl[k].err));
      if (k == SNAP_ROW) chk("snapshot_regs", a_regs, 64'h11003C12A5000022);
    end

    // Random traffic against the model
    step_a(1, 0, 0, 0, 4'h0, 0);
    model_step(1, 0, 0, 0, 4'h0, 0);
    for (int n = 0; n < 600; n++) begin
      logic r, e, s, ad, c;
      logic [3:0] d;
      int ea;
      r  = ($urandom_range(63) == 0);
      e  = ($urandom_range(7) != 0);
      s  = $urandom_range(1);
      ad = ($urandom_range(3) == 0);
      d  = 4'($urandom_range(15));
      c  = ($urandom_range(7) == 0);
      step_a(r, e, s, ad, d, c);
      model_step(r, e, s, ad, d, c);
      ea = m_addr;
      chk($sformatf("rnd%0d_regs", n),  a_regs, model_regs());
      chk($sformatf("rnd%0d_addr", n),  64'(a_addr),  64'(ea));
      chk($sformatf("rnd%0d_rd", n),    64'(a_rd),    (ea < 8) ? 64'(m_lv[ea]) : 64'd0);
      chk($sformatf("rnd%0d_dirty", n), 64'(a_dirty), 64'(m_dirty));
      chk($sformatf("rnd%0d_done", n),  64'(a_done),  64'(m_done));
      chk($sformatf("rnd%0d_err", n),   64'(a_err),   64'(m_err));
    end
    step_a(0, 0, 0, 0, 4'h0, 0);

    // Sweep build: direct writes, two-nybble address
    step_b(1, 0, 0, 0, 4'h0, 0);
    chk("b_reset_regs", 64'(b_regs == '0), 64'd1);
    chk("b_reset_addr", 64'(b_addr), 64'h00);
    step_b(0, 1, 1, 1, 4'h1, 0);
    step_b(0, 1, 1, 1, 4'h3, 0);
    chk("b_addr_13", 64'(b_addr), 64'h13);
    step_b(0, 1, 1, 0, 4'hB, 0);
    step_b(0, 1, 1, 0, 4'hE, 0);
    step_b(0, 1, 1, 0, 4'hE, 0);
    chk("b_partial_live19", 64'(b_regs[19*16 +: 16]), 64'h0000);
    step_b(0, 1, 1, 0, 4'hF, 0);
    chk("b_live19", 64'(b_regs[19*16 +: 16]), 64'hBEEF);
    chk("b_done", 64'(b_done), 64'd1);
    chk("b_err", 64'(b_err), 64'd0);
    chk("b_wrap_addr", 64'(b_addr), 64'h00);
    chk("b_dirty_direct", 64'(b_dirty), 64'd0);
    step_b(0, 1, 0, 0, 4'h0, 1);
    chk("b_commit_dirty", 64'(b_dirty), 64'd0);
    chk("b_commit_live19", 64'(b_regs[19*16 +: 16]), 64'hBEEF);
    chk("b_commit_done", 64'(b_done), 64'd0);
    step_b(0, 1, 1, 1, 4'h1, 0);
    step_b(0, 1, 1, 1, 4'h3, 0);
    chk("b_rd19", 64'(b_rd), 64'hBEEF);
    step_b(0, 1, 1, 0, 4'hB, 0);
    step_b(0, 1, 1, 0, 4'hE, 0);
    step_b(1, 1, 0, 0, 4'h0, 0);
    chk("b_rst_regs", 64'(b_regs == '0), 64'd1);
    chk("b_rst_addr", 64'(b_addr), 64'h00);
    step_b(0, 1, 1, 0, 4'h1, 0);
    step_b(0, 1, 1, 0, 4'h2, 0);
    step_b(0, 1, 1, 0, 4'h3, 0);
    step_b(0, 1, 1, 0, 4'h4, 0);
    chk("b_live0", 64'(b_regs[15:0]), 64'h1234);
    chk("b_addr_inc", 64'(b_addr), 64'h01);
    step_b(0, 1, 1, 1, 4'h2, 0);
    step_b(0, 1, 1, 1, 4'h0, 0);
    chk("b_rd_oor", 64'(b_rd), 64'h0000);
    for (int i = 0; i < 4; i++) step_b(0, 1, 1, 0, 4'h5, 0);
    chk("b_oor_err", 64'(b_err), 64'd1);
    chk("b_oor_addr", 64'(b_addr), 64'h00);
    chk("b_oor_rd0", 64'(b_rd), 64'h1234);
    chk("b_oor_regs", 64'(b_regs == 320'h1234), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
